muldiv_sequencer: RTL and testbench

//  Iterative multiply/divide controller beside the EX stage. Accepts MULT/MULTU/DIV/DIVU

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_iter_step.sv | 34 +++
 rtl/muldiv_sequencer.sv | 148 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } muldiv_state_t;

  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration: shift-add for multiply, shift-compare-subtract for divide.
module muldiv_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    // Divide: acc = {partial remainder, remaining dividend bits / quotient bits}
    rem_sh  = acc_in[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh[WIDTH-1:0] - operand;
    acc_out = acc_in;
    if (is_div) begin
      if (rem_sh >= {1'b0, operand}) begin
        acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end else if (acc_in[0]) begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end else begin
      acc_out = {1'b0, acc_in[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller with HI/LO registers and MTHI/MTLO access.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  muldiv_state_t      state, state_n;
  muldiv_op_t         op_in, op_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic [WIDTH-1:0]   opnd, a_raw, a_abs, b_abs;
  logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;
  logic               sign_a, sign_b, b_zero;
  logic               in_signed, in_div, is_div;
  logic               load, step, commit, mt_wr;

  assign op_in     = muldiv_op_t'(op);
  assign in_signed = is_signed_op(op_in);
  assign in_div    = is_div_op(op_in);
  assign is_div    = is_div_op(op_q);
  assign a_abs     = (in_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign b_abs     = (in_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  assign stall     = (state != S_IDLE);

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_in  (acc),
    .operand (opnd),
    .acc_out (acc_step)
  );

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    mt_wr   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (!flush) begin
            state_n = S_RUN;
            load    = 1'b1;
          end
        end else begin
          mt_wr = mt_hi | mt_lo;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == '0) state_n = S_FIX;
      end
      S_FIX: begin
        state_n = S_IDLE;
        commit  = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    // Flush squashes everything in flight, including a completing FIX.
    if (flush) begin
      state_n = S_IDLE;
      step    = 1'b0;
      commit  = 1'b0;
    end
  end

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quot     = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (b_zero) begin
        res_lo = '1;
        res_hi = a_raw;
      end else begin
        res_lo = (sign_a ^ sign_b) ? -quot : quot;
        res_hi = sign_a ? -rem : rem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      op_q   <= OP_MULT;
    end else begin
      done <= commit;
      if (load) begin
        op_q   <= op_in;
        a_raw  <= operand_a;
        sign_a <= in_signed & operand_a[WIDTH-1];
        sign_b <= in_signed & operand_b[WIDTH-1];
        b_zero <= (operand_b == '0);
        cnt    <= CW'(WIDTH - 1);
        // Multiply walks |b| out of the low half; divide walks |a| through it.
        acc    <= {{WIDTH{1'b0}}, (in_div ? a_abs : b_abs)};
        opnd   <= in_div ? b_abs : a_abs;
      end
      if (step) begin
        acc <= acc_step;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (commit) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (mt_wr) begin
        if (mt_hi) hi <= mt_data;
        if (mt_lo) lo <= mt_data;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed scoreboard bench for muldiv_sequencer.
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              reset, start, mt_hi, mt_lo, flush;
  logic [1:0]        op;
  logic [WIDTH-1:0]  operand_a, operand_b, mt_data;
  logic              stall, done;
  logic [WIDTH-1:0]  hi, lo;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  logic [31:0] cur_hi, cur_lo;

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .mt_hi     (mt_hi),
    .mt_lo     (mt_lo),
    .mt_data   (mt_data),
    .flush     (flush),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    logic [63:0] ua, ub;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (o)
      2'b00: return 64'(sa * sb_);
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb_;
        r = sa % sb_;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // mode 0: plain; 1: mt_lo alongside start; 2: mt_lo and a second start mid-run
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int mode);
    logic [63:0] m;
    exp_t        e;
    int          stall_err, done_err;
    logic        done34, done35;
    logic [31:0] got_hi, got_lo;
    m = model(o, a, b);
    sb.push_back('{hi: m[63:32], lo: m[31:0]});
    stall_err = 0;
    done_err  = 0;
    done34    = 1'b0;
    done35    = 1'b1;
    got_hi    = '0;
    got_lo    = '0;
    @(negedge clk);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    if (mode == 1) begin
      mt_lo   = 1'b1;
      mt_data = 32'hA5A5_0001;
    end
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        if (mode == 1) begin
          mt_lo = 1'b0;
          chk({tag, "_mt_with_start"}, {32'd0, lo}, {32'd0, cur_lo});
        end
      end
      if (n <= 33 && stall !== 1'b1) stall_err++;
      if (n >= 34 && stall !== 1'b0) stall_err++;
      if (n != 34 && n != 35 && done !== 1'b0) done_err++;
      if (n == 34) begin
        done34 = done;
        got_hi = hi;
        got_lo = lo;
      end
      if (n == 35) done35 = done;
      if (mode == 2 && n == 5) begin
        mt_lo     = 1'b1;
        mt_data   = 32'h5A5A_0002;
        start     = 1'b1;
        op        = ~o;
        operand_a = 32'h1111_1111;
        operand_b = 32'h3;
      end
      if (mode == 2 && n == 6) begin
        mt_lo = 1'b0;
        start = 1'b0;
        chk({tag, "_mt_busy"}, {32'd0, lo}, {32'd0, cur_lo});
      end
    end
    chk({tag, "_stall_window"}, 64'(stall_err), 64'd0);
    chk({tag, "_done_pulse"}, {61'd0, done34, done35, (done_err == 0)}, {61'd0, 3'b101});
    e = sb.pop_front();
    chk({tag, "_result"}, {got_hi, got_lo}, {e.hi, e.lo});
    cur_hi = e.hi;
    cur_lo = e.lo;
  endtask

  // Abort a MULT at cycle T+10 with flush (kind 0) or reset (kind 1).
  task automatic abort_op(input string tag, input int kind);
    int done_err;
    done_err = 0;
    @(negedge clk);
    start     = 1'b1;
    op        = 2'b00;
    operand_a = 32'h0000_0123;
    operand_b = 32'h0000_0456;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (done !== 1'b0) done_err++;
      if (n == 10) begin
        if (kind == 0) flush = 1'b1;
        else           reset = 1'b1;
      end
      if (n == 11) begin
        flush = 1'b0;
        reset = 1'b0;
      end
    end
    if (kind == 1) begin
      cur_hi = '0;
      cur_lo = '0;
    end
    chk({tag, "_stall"}, {63'd0, stall}, 64'd0);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || stall !== 1'b0) done_err++;
    end
    chk({tag, "_no_done"}, 64'(done_err), 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, {cur_hi, cur_lo});
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    op        = 2'b00;
    operand_a = '0;
    operand_b = '0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    mt_data   = '0;
    flush     = 1'b0;
    cur_hi    = '0;
    cur_lo    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", {60'd0, stall, done, (hi == 0), (lo == 0)}, {60'd0, 4'b0011});

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    chk("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu", 2'b11, 32'd7, 32'd2, 0);
    run_op("div_zero", 2'b10, 32'd5, 32'd0, 0);
    chk("div_zero_const", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("divu_zero", 2'b11, 32'hDEAD_BEEF, 32'd0, 0);
    run_op("div_negb", 2'b10, 32'd100, 32'hFFFF_FFF9, 0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_op($sformatf("rand%0d", i), 2'(i % 4), ra, rb, 0);
    end

    abort_op("flush_mid", 0);
    abort_op("reset_mid", 1);

    @(negedge clk);
    mt_hi   = 1'b1;
    mt_data = 32'h0000_1234;
    @(negedge clk);
    mt_hi = 1'b0;
    chk("mthi_idle", {hi, lo}, {32'h0000_1234, cur_lo});
    cur_hi = 32'h0000_1234;

    mt_hi   = 1'b1;
    mt_lo   = 1'b1;
    mt_data = 32'hCAFE_F00D;
    @(negedge clk);
    mt_hi = 1'b0;
    mt_lo = 1'b0;
    chk("mt_both", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
    cur_hi = 32'hCAFE_F00D;
    cur_lo = 32'hCAFE_F00D;

    run_op("mt_busy_op", 2'b01, 32'h0001_0000, 32'h0003_0000, 2);
    run_op("mt_start_op", 2'b11, 32'd1000, 32'd7, 1);

    start     = 1'b1;
    flush     = 1'b1;
    op        = 2'b00;
    operand_a = 32'd9;
    operand_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_idle", {63'd0, stall}, 64'd0);
    repeat (36) @(negedge clk);
    chk("flush_start_hilo", {hi, lo}, {cur_hi, cur_lo});

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
